gpio_bank: RTL and testbench

- Parametrised bidirectional GPIO bank that replaces per-pin hard-wired tri-state assignments in board top levels.
- Each pin has:
  - a register-controlled output enable and output value;
  - an optional open-drain mode;
  - a synchronised input;
  - rising/falling edge detection with sticky, write-1-to-clear status bits and a combined interrupt.
- Instantiated once per board top level, between the physical pins and the user logic's register bus.

---
 rtl/gpio_bank.sv | 100 ++++++++++
 tb/tb_gpio_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: register-controlled bidirectional GPIO bank with open-drain, input sync and edge interrupts
module gpio_bank #(
  parameter int          NUM_PINS    = 18,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  inout  wire  [NUM_PINS-1:0] pin,
  input  logic                bus_valid,
  input  logic                bus_write,
  input  logic [3:0]          bus_addr,
  input  logic [NUM_PINS-1:0] bus_wdata,
  output logic                bus_ready,
  output logic [NUM_PINS-1:0] bus_rdata,
  output logic                irq
);
  typedef enum logic {IDLE, ACK} state_t;
  localparam logic [NUM_PINS-1:0] OUT_INIT = RESET_OUT[NUM_PINS-1:0];
  state_t state, state_n;
  logic [NUM_PINS-1:0] out_q, oe_q, od_q, rise_en_q, fall_en_q, status_q;
  logic [NUM_PINS-1:0] in_sync, in_prev, event_hit, w1c, rd_mux;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic accept, wr;
  assign accept    = (state == IDLE) && bus_valid;
  assign wr        = accept && bus_write;
  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign event_hit = (in_sync & ~in_prev & rise_en_q) | (~in_sync & in_prev & fall_en_q);
  assign w1c       = (wr && bus_addr == 4'd6) ? bus_wdata : '0;
  assign irq       = |status_q;
  // A pad is released whenever OE is low or an open-drain pin wants to output 1
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
    assign pin[g] = (oe_q[g] && !(od_q[g] && out_q[g])) ? out_q[g] : 1'bz;
  end
  // Bus state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  // ACK always returns to IDLE, so a held request is accepted every second cycle
  always_comb state_n = accept ? ACK : IDLE;
  // Acknowledge is high for exactly the ACK cycle
  always_comb bus_ready = (state == ACK);
  // Read data is captured at the accepting edge so it is stable throughout ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bus_rdata <= '0;
    else if (accept) bus_rdata <= bus_write ? '0 : rd_mux;
  end
  // Register read multiplexer; write-only and unmapped addresses read 0
  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      4'd0:    rd_mux = out_q;
      4'd1:    rd_mux = oe_q;
      4'd2:    rd_mux = od_q;
      4'd3:    rd_mux = in_sync;
      4'd4:    rd_mux = rise_en_q;
      4'd5:    rd_mux = fall_en_q;
      4'd6:    rd_mux = status_q;
      default: rd_mux = '0;
    endcase
  end
  // Control register writes, including atomic set/clear views of OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= OUT_INIT;
      oe_q      <= '0;
      od_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr) begin
      case (bus_addr)
        4'd0:    out_q     <= bus_wdata;
        4'd1:    oe_q      <= bus_wdata;
        4'd2:    od_q      <= bus_wdata;
        4'd4:    rise_en_q <= bus_wdata;
        4'd5:    fall_en_q <= bus_wdata;
        4'd7:    out_q     <= out_q | bus_wdata;
        4'd8:    out_q     <= out_q & ~bus_wdata;
        default: ;
      endcase
    end
  end
  // Sticky status: a new event in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= (status_q & ~w1c) | event_hit;
  end
  // Input synchroniser chain plus previous-value register for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      in_prev <= in_sync;
    end
  end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard bench for gpio_bank with pulled-up pads and external pad drivers
module tb_gpio_bank;
  localparam int N = 18;
  typedef struct {
    bit           rd;
    logic [N-1:0] exp;
    logic [3:0]   addr;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_valid = 1'b0;
  logic bus_write = 1'b0;
  logic [3:0] bus_addr = '0;
  logic [N-1:0] bus_wdata = '0;
  logic bus_ready, irq;
  logic [N-1:0] bus_rdata;
  logic [N-1:0] ext_en = '0;
  logic [N-1:0] ext_val = '0;
  wire  [N-1:0] pin;
  int errors = 0;
  int checks = 0;
  txn_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pad
    pullup (pin[g]);
    assign pin[g] = ext_en[g] ? ext_val[g] : 1'bz;
  end

  gpio_bank #(.NUM_PINS(N), .SYNC_STAGES(2), .RESET_OUT(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .pin(pin),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .irq(irq)
  );

  task automatic xfer(input bit wr, input logic [3:0] a, input logic [N-1:0] d, input logic [N-1:0] exp, output int lat);
    txn_t t;
    @(negedge clk);
    bus_valid = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = d;
    sb.push_back('{rd: !wr, exp: exp, addr: a});
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus_ready) lat = c;
    end
    bus_valid = 1'b0;
    @(negedge clk);
    t = sb.pop_front();
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%0d got no ack, want ack within 8 cycles", a);
    end else if (t.rd) begin
      checks++;
      if (bus_rdata !== t.exp) begin
        errors++;
        $display("FAIL rdata addr=%0d got=%h want=%h", t.addr, bus_rdata, t.exp);
      end
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [N-1:0] d);
    int l;
    xfer(1'b1, a, d, '0, l);
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [N-1:0] exp);
    int l;
    xfer(1'b0, a, '0, exp, l);
  endtask

  task automatic test_reset;
    int l;
    rst_n = 1'b0; bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 4'd0;
    ext_en = 18'h15555; ext_val = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pin !== 18'h2AAAA) begin errors++; $display("FAIL reset_pins got=%h want=%h", pin, 18'h2AAAA); end
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    checks++; if (bus_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h want=0", bus_rdata); end
    @(negedge clk);
    bus_valid = 1'b0; ext_en = '0; rst_n = 1'b1;
    xfer(1'b0, 4'd0, '0, 18'h0, l);
    checks++; if (l != 1) begin errors++; $display("FAIL reset_ack_latency got=%0d want=1", l); end
    @(posedge clk); #1;
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL ack_single_pulse got=%b want=0", bus_ready); end
  endtask

  task automatic test_push_pull;
    wr_reg(4'd1, 18'h3);
    wr_reg(4'd0, 18'h1);
    checks++; if (pin !== 18'h3FFFD) begin errors++; $display("FAIL pp_drive got=%h want=%h", pin, 18'h3FFFD); end
    ext_en = 18'h3FFFC; ext_val = '0; #1;
    checks++; if (pin !== 18'h00001) begin errors++; $display("FAIL pp_hiz got=%h want=%h", pin, 18'h00001); end
    ext_en = '0; #1;
    wr_reg(4'd7, 18'h2);
    checks++; if (pin[1:0] !== 2'b11) begin errors++; $display("FAIL pp_out_set got=%b want=11", pin[1:0]); end
    wr_reg(4'd8, 18'h1);
    checks++; if (pin !== 18'h3FFFE) begin errors++; $display("FAIL pp_out_clr got=%h want=%h", pin, 18'h3FFFE); end
    rd_reg(4'd0, 18'h2);
    rd_reg(4'd1, 18'h3);
  endtask

  task automatic test_open_drain;
    wr_reg(4'd2, 18'h10);
    wr_reg(4'd1, 18'h13);
    checks++; if (pin !== 18'h3FFEE) begin errors++; $display("FAIL od_low got=%h want=%h", pin, 18'h3FFEE); end
    wr_reg(4'd7, 18'h10);
    checks++; if (pin !== 18'h3FFFE) begin errors++; $display("FAIL od_release got=%h want=%h", pin, 18'h3FFFE); end
    ext_en = 18'h10; ext_val = '0; #1;
    checks++; if (pin[4] !== 1'b0) begin errors++; $display("FAIL od_hiz got=%b want=0", pin[4]); end
    ext_en = '0;
    repeat (2) @(negedge clk);
    rd_reg(4'd3, 18'h3FFFE);
    rd_reg(4'd0, 18'h12);
  endtask

  task automatic test_bus_corners;
    rd_reg(4'd12, 18'h0);
    rd_reg(4'd7, 18'h0);
    rd_reg(4'd8, 18'h0);
    wr_reg(4'd3, 18'h0);
    rd_reg(4'd3, 18'h3FFFE);
    wr_reg(4'd12, 18'h3FFFF);
    rd_reg(4'd0, 18'h12);
    rd_reg(4'd15, 18'h0);
  endtask

  task automatic test_back_to_back;
    txn_t t;
    logic exp_rdy;
    @(negedge clk);
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 4'd1;
    repeat (3) sb.push_back('{rd: 1'b1, exp: 18'h13, addr: 4'd1});
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      exp_rdy = c[0];
      checks++; if (bus_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready cycle=%0d got=%b want=%b", c, bus_ready, exp_rdy); end
      if (bus_ready && sb.size() > 0) begin
        t = sb.pop_front();
        checks++; if (bus_rdata !== t.exp) begin errors++; $display("FAIL b2b_rdata cycle=%0d got=%h want=%h", c, bus_rdata, t.exp); end
      end
    end
    bus_valid = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_ack_count got=%0d want=3", 3 - sb.size()); end
    sb.delete();
  endtask

  task automatic test_edge_detect;
    ext_en = 18'h8; ext_val = '0;
    repeat (4) @(negedge clk);
    wr_reg(4'd4, 18'h8);
    ext_val[3] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++; if (irq !== (c == 3)) begin errors++; $display("FAIL rise_latency edge=%0d got=%b want=%b", c, irq, c == 3); end
    end
    rd_reg(4'd6, 18'h8);
    ext_val[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd_reg(4'd6, 18'h8);
    wr_reg(4'd6, 18'h8);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b want=0", irq); end
    wr_reg(4'd4, 18'h0);
    wr_reg(4'd5, 18'h8);
    ext_val[3] = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_disabled got=%b want=0", irq); end
    ext_val[3] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_detect got=%b want=1", irq); end
    wr_reg(4'd5, 18'h0);
    rd_reg(4'd6, 18'h8);
    wr_reg(4'd6, 18'h8);
    rd_reg(4'd6, 18'h0);
  endtask

  task automatic test_collision;
    wr_reg(4'd4, 18'h8);
    ext_val[3] = 1'b1;
    repeat (2) @(posedge clk);
    wr_reg(4'd6, 18'h8);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq got=%b want=1", irq); end
    rd_reg(4'd6, 18'h8);
    wr_reg(4'd6, 18'h8);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collision_clear got=%b want=0", irq); end
  endtask

  task automatic test_reset_in_ack;
    wr_reg(4'd5, 18'h8);
    ext_val[3] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b want=1", irq); end
    @(negedge clk);
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 4'd0; bus_wdata = 18'h3FFFF;
    @(posedge clk); #1;
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL ack_before_reset got=%b want=1", bus_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL reset_drops_ready got=%b want=0", bus_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_clears_irq got=%b want=0", irq); end
    checks++; if (pin !== 18'h3FFF7) begin errors++; $display("FAIL reset_releases_pins got=%h want=%h", pin, 18'h3FFF7); end
    @(negedge clk);
    bus_valid = 1'b0; ext_en = '0; rst_n = 1'b1;
    rd_reg(4'd0, 18'h0);
    rd_reg(4'd1, 18'h0);
    rd_reg(4'd2, 18'h0);
    rd_reg(4'd5, 18'h0);
    rd_reg(4'd6, 18'h0);
  endtask

  initial begin
    test_reset;
    test_push_pull;
    test_open_drain;
    test_bus_corners;
    test_back_to_back;
    test_edge_detect;
    test_collision;
    test_reset_in_ack;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=still running want=finished");
    $fatal(1, "timeout");
  end
endmodule
